// File: rtl/hazard_ctl_pkg.sv
// Shared sizing and types for the hazard controller: register file geometry,
// pending/in-flight counter widths and the held-slot descriptor.
package hazard_ctl_pkg;

  localparam int REGNO     = 8;
  localparam int REGNO_LOG = 3;
  localparam int PEND_W    = 2;
  localparam int INFL_W    = 3;

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_HELD  = 1'b1
  } slot_state_t;

  typedef struct packed {
    logic [REGNO_LOG-1:0] l_reg;
    logic [REGNO_LOG-1:0] r_reg;
    logic [1:0]           used;
    logic [REGNO-1:0]     rf_ie;
  } slot_hdr_t;

endpackage

// File: rtl/hazard_ctl_pend_ctr.sv
// Per-register outstanding-write counter: saturating up/down, simultaneous
// inc+dec holds, decrement at zero holds at zero. Count visible next cycle.
module pend_ctr
  import hazard_ctl_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_inc,
  input  logic              i_dec,
  output logic [PEND_W-1:0] o_cnt,
  output logic              o_nz
);

  logic [PEND_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_inc && !i_dec && (cnt_q != PEND_MAX)) begin
      cnt_d = cnt_q + PEND_W'(1);
    end else if (!i_inc && i_dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - PEND_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;
  assign o_nz  = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctl.sv
// Single-slot issue stage: holds one decoded instruction until its sources and
// destination are free; issue appears on o_submit one cycle after the slot is issuable.
// Backpressure: o_ready drops while the slot is stuck, execute is not ready, or a flush is active.
module hazard_ctl
  import hazard_ctl_pkg::*;
#(
  parameter int CTL_W    = 64,
  parameter int MAX_INFL = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_submit,
  output logic                 o_ready,
  input  logic [CTL_W-1:0]     i_ctl,
  input  logic [REGNO_LOG-1:0] i_l_reg_sel,
  input  logic [REGNO_LOG-1:0] i_r_reg_sel,
  input  logic [1:0]           i_used_operands,
  input  logic [REGNO-1:0]     i_rf_ie,
  output logic                 o_submit,
  output logic [CTL_W-1:0]     o_ctl,
  output logic [REGNO-1:0]     o_rf_ie,
  input  logic                 i_next_ready,
  input  logic                 i_ret_valid,
  input  logic [REGNO-1:0]     i_ret_mask,
  input  logic                 i_flush,
  output logic [15:0]          o_stall_cnt
);

  slot_state_t       state_q, state_d;
  slot_hdr_t         hdr_q, hdr_d;
  logic [CTL_W-1:0]  ctl_q, ctl_d;
  logic              submit_q, submit_d;
  logic [CTL_W-1:0]  out_ctl_q, out_ctl_d;
  logic [REGNO-1:0]  out_rf_q, out_rf_d;
  logic [INFL_W-1:0] infl_q, infl_d;
  logic [15:0]       stall_q, stall_d;

  logic [PEND_W-1:0] pend_cnt [REGNO];
  logic [REGNO-1:0]  pend_nz;
  logic [REGNO-1:0]  pend_full;
  logic              hazard, issue_ok, accept;

  for (genvar g = 0; g < REGNO; g++) begin : g_pend
    pend_ctr u_pend_ctr (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_inc  (issue_ok & hdr_q.rf_ie[g]),
      .i_dec  (i_ret_valid & i_ret_mask[g]),
      .o_cnt  (pend_cnt[g]),
      .o_nz   (pend_nz[g])
    );
    assign pend_full[g] = (pend_cnt[g] == PEND_MAX);
  end

  // Registered counters only, so a retire frees the slot one cycle later.
  assign hazard = (hdr_q.used[0] & pend_nz[hdr_q.l_reg])
                | (hdr_q.used[1] & pend_nz[hdr_q.r_reg])
                | (|(hdr_q.rf_ie & pend_full))
                | (infl_q == INFL_W'(MAX_INFL));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= SLOT_EMPTY;
      hdr_q     <= '0;
      ctl_q     <= '0;
      submit_q  <= 1'b0;
      out_ctl_q <= '0;
      out_rf_q  <= '0;
      infl_q    <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      hdr_q     <= hdr_d;
      ctl_q     <= ctl_d;
      submit_q  <= submit_d;
      out_ctl_q <= out_ctl_d;
      out_rf_q  <= out_rf_d;
      infl_q    <= infl_d;
      stall_q   <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    ctl_d   = ctl_q;
    if (i_flush) begin
      state_d = SLOT_EMPTY;
    end else if (accept) begin
      state_d = SLOT_HELD;
      hdr_d   = '{l_reg: i_l_reg_sel, r_reg: i_r_reg_sel,
                  used: i_used_operands, rf_ie: i_rf_ie};
      ctl_d   = i_ctl;
    end else if (issue_ok) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_comb begin
    issue_ok = (state_q == SLOT_HELD) & ~hazard & i_next_ready & ~i_flush;
    o_ready  = i_next_ready & ~i_flush & ((state_q == SLOT_EMPTY) | issue_ok);
    accept   = i_submit & o_ready;
  end

  always_comb begin
    submit_d  = issue_ok;
    out_ctl_d = issue_ok ? ctl_q : out_ctl_q;
    out_rf_d  = issue_ok ? hdr_q.rf_ie : out_rf_q;

    infl_d = infl_q;
    if (issue_ok && !i_ret_valid) begin
      infl_d = infl_q + INFL_W'(1);
    end else if (!issue_ok && i_ret_valid && (infl_q != '0)) begin
      infl_d = infl_q - INFL_W'(1);
    end

    stall_d = stall_q;
    if ((state_q == SLOT_HELD) && hazard && !i_flush && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  assign o_submit    = submit_q;
  assign o_ctl       = out_ctl_q;
  assign o_rf_ie     = out_rf_q;
  assign o_stall_cnt = stall_q;

endmodule

// File: doc/hazard_ctl.md
HAZARD_CTL -- requirements
Module: hazard_ctl

Interface
REQ-001 SHALL have parameter CTL_W, default 64, meaning width of the opaque decoded-control payload passed through.
REQ-002 SHALL have parameter MAX_INFL, default 4, meaning the maximum number of instructions issued but not yet retired (1..7).
REQ-003 i_clk  in  1  clock; single clock domain, all state on rising edge.
REQ-004 i_rst_n  in  1  reset; asynchronous and active-low.
REQ-005 i_submit  in  1  decode offers an instruction this cycle.
REQ-006 o_ready  out  1  combinational; hazard_ctl can accept the offer this cycle.
REQ-007 i_ctl  in  CTL_W  payload, captured with the instruction.
REQ-008 i_l_reg_sel, i_r_reg_sel  in  3 each  source register numbers.
REQ-009 i_used_operands  in  2  bit0 = left source read, bit1 = right source read.
REQ-010 i_rf_ie  in  8  one-hot (or zero) destination write mask.
REQ-011 o_submit  out  1  registered; one-cycle issue pulse to execute.
REQ-012 o_ctl  out  CTL_W  registered payload, valid while o_submit=1.
REQ-013 o_rf_ie  out  8  registered write mask of the issued instruction.
REQ-014 i_next_ready  in  1  execute can take an instruction.
REQ-015 i_ret_valid  in  1  one issued instruction retires (committed or squashed).
REQ-016 i_ret_mask  in  8  o_rf_ie value of the retiring instruction.
REQ-017 i_flush  in  1  discard the held instruction.
REQ-018 o_stall_cnt  out  16  saturating count of hazard stall cycles.

Function
REQ-019 SHALL hold one instruction in a slot with states EMPTY and HELD; i_submit & o_ready moves EMPTY->HELD (or HELD->HELD via same-cycle issue and refill).
REQ-020 o_ready SHALL equal i_next_ready & (slot EMPTY | issue_ok this cycle).
REQ-021 SHALL keep a 2-bit pending counter per register, incremented on issue for each bit set in o_rf_ie and decremented on retire for each bit set in i_ret_mask; simultaneous issue and retire on one register SHALL leave the counter unchanged.
REQ-022 SHALL keep a 3-bit in-flight counter: +1 per issue, -1 per retire, net 0 when both occur.
REQ-023 hazard SHALL be asserted when (used_operands[0] & pend[l_reg]!=0) | (used_operands[1] & pend[r_reg]!=0) | (written register has pend==3) | (inflight==MAX_INFL), using registered counters only; a retire clears a hazard one cycle later, never in the same cycle.
REQ-024 issue_ok SHALL be HELD & ~hazard & i_next_ready & ~i_flush; on issue_ok, o_submit=1, o_ctl/o_rf_ie are loaded next edge (one-cycle latency from HELD to o_submit).
REQ-025 write-after-write to a register with pend in 1..2 SHALL NOT stall.
REQ-026 i_flush SHALL return the slot to EMPTY, suppress issue and acceptance that cycle, and leave pending and in-flight counters unchanged (execute retires killed instructions via i_ret_*).
REQ-027 o_stall_cnt SHALL increment on every cycle with HELD & hazard & ~i_flush, saturating at 16'hFFFF.
REQ-028 a retire whose mask bit targets a counter at 0, or with inflight 0, is a protocol error; the counter SHALL stay at 0 (no wrap).

Reset
REQ-029 while i_rst_n=0: slot EMPTY, o_submit=0, o_ctl=0, o_rf_ie=0, all pending counters 0, inflight 0, o_stall_cnt 0; asynchronous assert, synchronous-release usage by top level.
REQ-030 reset mid-operation SHALL drop the held instruction with no o_submit pulse.

Structure
REQ-031 REGNO (8), REGNO_LOG (3), PEND_W (2), INFL_W (3) SHALL live in the shared config package.
REQ-032 one sub-module, pend_ctr (single saturating up/down counter with nonzero flag), SHALL be instantiated REGNO times.

Verification
REQ-033 Back-to-back independent ADDs (rf_ie 0x02 then 0x04, sources r5/r6) with i_next_ready=1 -> two consecutive o_submit pulses, o_stall_cnt=0.
REQ-034 Issue write to r3, next instruction reads r3 (used_operands=01, l=3) -> held, o_ready=0, o_stall_cnt increments; i_ret_mask=0x08 -> o_submit exactly two cycles after retire edge.
REQ-035 Five writers to distinct registers, no retires, MAX_INFL=4 -> four issues, fifth held until one i_ret_valid, then issues.
REQ-036 HELD hazard instruction plus i_flush -> no o_submit, slot EMPTY, pending counters unchanged; next offer accepted same cycle as flush deassert.
REQ-037 Same-cycle issue writing r1 and retire mask 0x02 with pend[1]=1 -> pend[1] stays 1, inflight unchanged.
REQ-038 Drop i_rst_n while HELD and pend[2]=2 -> immediate o_submit=0, all counters 0, no issue after release until new i_submit.
